// File: rtl/diff_freq_cmd_scheduler.sv
// diff_freq_cmd_scheduler
//   Parses framed UART commands (0xA5, CMD, CHAN, LEN, payload, CHK) and
//   turns them into datapath configuration writes, per-channel start/stop
//   pulses and a one-byte ACK/NAK response.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   rx_data_i         received UART byte, valid while rx_done_tick_i = 1
//   rx_done_tick_i    one-cycle receive strobe
//   tx_busy_i         UART transmitter busy
//   tx_start_o        one-cycle strobe sending tx_data_o
//   tx_data_o         response byte (0x06 ACK, 0x15 NAK)
//   cfg_we_o          configuration write strobe
//   cfg_chan_o        target channel of the write
//   cfg_addr_o        configuration register index
//   cfg_data_o        configuration write data
//   start_o, stop_o   one-cycle per-channel start / stop pulses
//   err_o             one-cycle pulse on NAK or inter-byte timeout
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | hunting for the 0xA5 start byte
// CMD     | waiting for the command byte
// CHAN    | waiting for the channel byte
// LEN     | waiting for the length byte, frame legality decided here
// PAYLOAD | buffering payload bytes 0..LEN-1
// CHK     | waiting for the checksum byte
// EXEC    | one configuration write per cycle, index 0..LEN-1
// ACT     | start/stop pulse cycle
// RESP    | holding ACK/NAK until the transmitter is free

module diff_freq_cmd_scheduler #(
    parameter int DATA_BIT       = 8,
    parameter int OUTPUT_NUM     = 16,
    parameter int PAYLOAD_MAX    = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int CW = (OUTPUT_NUM  > 1) ? $clog2(OUTPUT_NUM)  : 1,
    localparam int AW = (PAYLOAD_MAX > 1) ? $clog2(PAYLOAD_MAX) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_BIT-1:0]   rx_data_i,
    input  logic                  rx_done_tick_i,
    input  logic                  tx_busy_i,
    output logic                  tx_start_o,
    output logic [DATA_BIT-1:0]   tx_data_o,
    output logic                  cfg_we_o,
    output logic [CW-1:0]         cfg_chan_o,
    output logic [AW-1:0]         cfg_addr_o,
    output logic [DATA_BIT-1:0]   cfg_data_o,
    output logic [OUTPUT_NUM-1:0] start_o,
    output logic [OUTPUT_NUM-1:0] stop_o,
    output logic                  err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_CMD  = 4'd1;
    localparam logic [3:0] S_CHAN = 4'd2;
    localparam logic [3:0] S_LEN  = 4'd3;
    localparam logic [3:0] S_PAY  = 4'd4;
    localparam logic [3:0] S_CHK  = 4'd5;
    localparam logic [3:0] S_EXEC = 4'd6;
    localparam logic [3:0] S_ACT  = 4'd7;
    localparam logic [3:0] S_RESP = 4'd8;

    localparam logic [DATA_BIT-1:0] SOF           = DATA_BIT'(8'hA5);
    localparam logic [DATA_BIT-1:0] ACK           = DATA_BIT'(8'h06);
    localparam logic [DATA_BIT-1:0] NAK           = DATA_BIT'(8'h15);
    localparam logic [DATA_BIT-1:0] CMD_WRITE     = DATA_BIT'(8'h01);
    localparam logic [DATA_BIT-1:0] CMD_START     = DATA_BIT'(8'h02);
    localparam logic [DATA_BIT-1:0] CMD_STOP      = DATA_BIT'(8'h03);
    localparam logic [DATA_BIT-1:0] CMD_START_ALL = DATA_BIT'(8'h04);

    logic [3:0]          state_q, state_d;
    logic [DATA_BIT-1:0] cmd_q, cmd_d;
    logic [DATA_BIT-1:0] chan_q, chan_d;
    logic [DATA_BIT-1:0] len_q, len_d;
    logic [DATA_BIT-1:0] chk_q, chk_d;
    logic [AW:0]         idx_q, idx_d;
    logic [TW-1:0]       cnt_q, cnt_d;
    logic [DATA_BIT-1:0] resp_q, resp_d;
    logic                err_q, err_d;
    logic [DATA_BIT-1:0] pay_q [PAYLOAD_MAX];
    logic                pay_we;

    logic                rx_state;
    logic                timeout;
    logic                frame_bad;
    logic                last_idx;
    logic [OUTPUT_NUM-1:0] chan_onehot;

    assign rx_state = (state_q >= S_CMD) && (state_q <= S_CHK);
    assign timeout  = rx_state && !rx_done_tick_i && (cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign last_idx = (int'(idx_q) == int'(len_q) - 1);

    // Evaluated on the LEN tick, so the length is taken straight from rx_data_i.
    assign frame_bad = !(cmd_q == CMD_WRITE || cmd_q == CMD_START ||
                         cmd_q == CMD_STOP  || cmd_q == CMD_START_ALL)
                    || (int'(rx_data_i) > PAYLOAD_MAX)
                    || (cmd_q != CMD_START_ALL && int'(chan_q) >= OUTPUT_NUM)
                    || (cmd_q != CMD_WRITE && rx_data_i != '0);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        chan_d  = chan_q;
        len_d   = len_q;
        chk_d   = chk_q;
        idx_d   = idx_q;
        resp_d  = resp_q;
        err_d   = 1'b0;
        pay_we  = 1'b0;
        cnt_d   = '0;
        if (rx_state && !rx_done_tick_i) begin
            cnt_d = cnt_q + TW'(1);
        end
        case (state_q)
            S_IDLE: if (rx_done_tick_i && rx_data_i == SOF) state_d = S_CMD;
            S_CMD: if (rx_done_tick_i) begin
                cmd_d   = rx_data_i;
                chk_d   = rx_data_i;
                state_d = S_CHAN;
            end
            S_CHAN: if (rx_done_tick_i) begin
                chan_d  = rx_data_i;
                chk_d   = chk_q ^ rx_data_i;
                state_d = S_LEN;
            end
            S_LEN: if (rx_done_tick_i) begin
                len_d = rx_data_i;
                chk_d = chk_q ^ rx_data_i;
                idx_d = '0;
                if (frame_bad) begin
                    resp_d  = NAK;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (rx_data_i == '0) begin
                    state_d = S_CHK;
                end else begin
                    state_d = S_PAY;
                end
            end
            S_PAY: if (rx_done_tick_i) begin
                pay_we = 1'b1;
                chk_d  = chk_q ^ rx_data_i;
                idx_d  = idx_q + (AW+1)'(1);
                if (last_idx) state_d = S_CHK;
            end
            S_CHK: if (rx_done_tick_i) begin
                idx_d = '0;
                if (rx_data_i == chk_q) begin
                    state_d = (len_q == '0) ? S_ACT : S_EXEC;
                end else begin
                    resp_d  = NAK;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_EXEC: begin
                idx_d = idx_q + (AW+1)'(1);
                if (last_idx) state_d = S_ACT;
            end
            S_ACT: begin
                resp_d  = ACK;
                state_d = S_RESP;
            end
            S_RESP: if (!tx_busy_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A timeout only fires on a cycle without a tick, so nothing above moved.
        if (timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            chan_q  <= '0;
            len_q   <= '0;
            chk_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < PAYLOAD_MAX; i++) pay_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            chan_q  <= chan_d;
            len_q   <= len_d;
            chk_q   <= chk_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            if (pay_we) pay_q[idx_q[AW-1:0]] <= rx_data_i;
        end
    end

    assign chan_onehot = OUTPUT_NUM'(1) << chan_q[CW-1:0];

    assign cfg_we_o   = (state_q == S_EXEC);
    assign cfg_chan_o = cfg_we_o ? chan_q[CW-1:0]          : '0;
    assign cfg_addr_o = cfg_we_o ? idx_q[AW-1:0]           : '0;
    assign cfg_data_o = cfg_we_o ? pay_q[idx_q[AW-1:0]]    : '0;

    assign start_o = (state_q != S_ACT)         ? '0 :
                     (cmd_q == CMD_START)       ? chan_onehot :
                     (cmd_q == CMD_START_ALL)   ? {OUTPUT_NUM{1'b1}} : '0;
    assign stop_o  = (state_q == S_ACT && cmd_q == CMD_STOP) ? chan_onehot : '0;

    assign tx_start_o = (state_q == S_RESP) && !tx_busy_i;
    assign tx_data_o  = resp_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_diff_freq_cmd_scheduler.sv
module tb_diff_freq_cmd_scheduler;

    localparam int DB = 8;
    localparam int ON = 16;
    localparam int PM = 4;
    localparam int TO = 200;

    logic          clk = 1'b0;
    logic          rst, tick, busy;
    logic [DB-1:0] rxd;
    logic          tx_start_o, cfg_we_o, err_o;
    logic [DB-1:0] tx_data_o, cfg_data_o;
    logic [3:0]    cfg_chan_o;
    logic [1:0]    cfg_addr_o;
    logic [ON-1:0] start_o, stop_o;

    diff_freq_cmd_scheduler #(
        .DATA_BIT(DB), .OUTPUT_NUM(ON), .PAYLOAD_MAX(PM), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .rx_data_i(rxd), .rx_done_tick_i(tick),
        .tx_busy_i(busy), .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
        .cfg_we_o(cfg_we_o), .cfg_chan_o(cfg_chan_o), .cfg_addr_o(cfg_addr_o),
        .cfg_data_o(cfg_data_o), .start_o(start_o), .stop_o(stop_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int val; } ev_t;
    ev_t mon_wr[$], mon_st[$], mon_sp[$], mon_tx[$], mon_er[$];
    ev_t exp_wr[$], exp_st[$], exp_sp[$], exp_tx[$], exp_er[$];

    always @(negedge clk) begin
        if (cfg_we_o)    mon_wr.push_back(ev_t'{cyc, (int'(cfg_chan_o) << 16) | (int'(cfg_addr_o) << 8) | int'(cfg_data_o)});
        if (start_o != 0) mon_st.push_back(ev_t'{cyc, int'(start_o)});
        if (stop_o != 0)  mon_sp.push_back(ev_t'{cyc, int'(stop_o)});
        if (tx_start_o)  mon_tx.push_back(ev_t'{cyc, int'(tx_data_o)});
        if (err_o)       mon_er.push_back(ev_t'{cyc, 0});
    end

    int total = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] all_outputs();
        return {7'd0, tx_start_o, tx_data_o, cfg_we_o, cfg_chan_o, cfg_addr_o,
                cfg_data_o, start_o, stop_o, err_o};
    endfunction

    task automatic cmp_events(input string tag, input ev_t got[$], input ev_t exp[$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check({tag, "_cycle"}, got[i].cyc, exp[i].cyc);
            check({tag, "_value"}, got[i].val, exp[i].val);
        end
    endtask

    task automatic clear_all();
        mon_wr.delete(); mon_st.delete(); mon_sp.delete(); mon_tx.delete(); mon_er.delete();
        exp_wr.delete(); exp_st.delete(); exp_sp.delete(); exp_tx.delete(); exp_er.delete();
    endtask

    task automatic verify(input string tag);
        cmp_events({tag, "_cfg"},   mon_wr, exp_wr);
        cmp_events({tag, "_start"}, mon_st, exp_st);
        cmp_events({tag, "_stop"},  mon_sp, exp_sp);
        cmp_events({tag, "_tx"},    mon_tx, exp_tx);
        cmp_events({tag, "_err"},   mon_er, exp_er);
        clear_all();
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b, output int t);
        rxd  = b;
        tick = 1'b1;
        t    = cyc;
        @(posedge clk); #1;
        tick = 1'b0;
        rxd  = '0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input int gap_max, output int t_last);
        foreach (f[i]) begin
            if (i > 0) idle($urandom_range(0, gap_max));
            send(f[i], t_last);
        end
    endtask

    // Frame legality as decided once CMD, CHAN and LEN are known.
    function automatic bit is_bad(input logic [7:0] f[$]);
        int cmd = f[1];
        int chan = f[2];
        int len = f[3];
        return !(cmd >= 1 && cmd <= 4) || len > PM ||
               (cmd != 4 && chan >= ON) || (cmd != 1 && len != 0);
    endfunction

    // Expected events for a frame beginning at 0xA5 whose last byte ticked at t.
    task automatic predict(input logic [7:0] f[$], input int t);
        int cmd = f[1];
        int chan = f[2];
        int len = f[3];
        logic [7:0] x;
        if (is_bad(f)) begin
            exp_tx.push_back(ev_t'{t + 1, 'h15});
            exp_er.push_back(ev_t'{t + 1, 0});
            return;
        end
        x = f[1] ^ f[2] ^ f[3];
        for (int i = 0; i < len; i++) x ^= f[4 + i];
        if (f[4 + len] != x) begin
            exp_tx.push_back(ev_t'{t + 1, 'h15});
            exp_er.push_back(ev_t'{t + 1, 0});
            return;
        end
        for (int i = 0; i < len; i++)
            exp_wr.push_back(ev_t'{t + 1 + i, (chan << 16) | (i << 8) | int'(f[4 + i])});
        if (cmd == 2) exp_st.push_back(ev_t'{t + len + 1, 1 << chan});
        if (cmd == 3) exp_sp.push_back(ev_t'{t + len + 1, 1 << chan});
        if (cmd == 4) exp_st.push_back(ev_t'{t + len + 1, (1 << ON) - 1});
        exp_tx.push_back(ev_t'{t + len + 2, 'h06});
    endtask

    task automatic run_frame(input string tag, input logic [7:0] f[$], input int gap_max);
        int t;
        send_frame(f, gap_max, t);
        predict(f, t);
        idle(int'(f[3] > PM ? 0 : f[3]) + 8);
        verify(tag);
    endtask

    initial begin
        logic [7:0] f[$];
        int t, t1, d;

        rst = 1'b1; tick = 1'b0; busy = 1'b0; rxd = '0;
        @(posedge clk); #1;
        idle(3);
        check("reset_outputs", all_outputs(), 64'd0);
        rst = 1'b0;
        clear_all();
        idle(2);

        // Two-byte WRITE to channel 3; checksum built from the fields.
        f = '{8'hA5, 8'h01, 8'h03, 8'h02, 8'h11, 8'h22};
        f.push_back(f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5]);
        run_frame("write2", f, 0);

        f = '{8'hA5, 8'h02, 8'h05, 8'h00, 8'h07};
        run_frame("start5", f, 0);

        f = '{8'hA5, 8'h01, 8'h03, 8'h01, 8'h44, 8'h00};
        run_frame("bad_chk", f, 0);

        f = '{8'hA5, 8'h02, 8'h10, 8'h00};
        run_frame("chan_range", f, 0);

        f = '{8'hA5, 8'h01, 8'h00, 8'h05};
        run_frame("len_range", f, 0);

        f = '{8'hA5, 8'h04, 8'h1F, 8'h00, 8'h1B};
        run_frame("start_all", f, 1);

        f = '{8'hA5, 8'h01, 8'h0F, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        f.push_back(f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5] ^ f[6] ^ f[7]);
        run_frame("write_max", f, 2);

        // Inter-byte timeout after A5 03.
        send(8'hA5, t);
        send(8'h03, t1);
        idle(TO + 10);
        check("timeout_err_count", mon_er.size(), 1);
        if (mon_er.size() >= 1)
            check("timeout_err_window",
                  (mon_er[0].cyc - t1 >= TO) && (mon_er[0].cyc - t1 <= TO + 1), 1'b1);
        check("timeout_tx_count", mon_tx.size(), 0);
        check("timeout_stop_count", mon_sp.size(), 0);
        clear_all();
        f = '{8'hA5, 8'h03, 8'h02, 8'h00, 8'h01};
        run_frame("after_timeout", f, 0);

        // Transmitter busy for 50 cycles of RESP; a stray 0xA5 there is dropped.
        busy = 1'b1;
        f = '{8'hA5, 8'h02, 8'h09, 8'h00, 8'h0B};
        send_frame(f, 0, t);
        exp_st.push_back(ev_t'{t + 1, 1 << 9});
        idle(8);
        send(8'hA5, t1);
        idle(t + 2 + 50 - cyc);
        busy = 1'b0;
        d = cyc;
        exp_tx.push_back(ev_t'{d, 'h06});
        idle(5);
        verify("busy_hold");
        f = '{8'h02, 8'h05, 8'h00, 8'h07};
        send_frame(f, 0, t);
        idle(8);
        verify("stray_sof_dropped");

        // Reset in the middle of a four-byte write.
        f = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
        f.push_back(f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5] ^ f[6] ^ f[7]);
        send_frame(f, 0, t);
        idle(1);
        rst = 1'b1;
        idle(1);
        check("reset_exec_outputs", all_outputs(), 64'd0);
        rst = 1'b0;
        idle(10);
        exp_wr.push_back(ev_t'{t + 1, (2 << 16) | (0 << 8) | 'h0A});
        exp_wr.push_back(ev_t'{t + 2, (2 << 16) | (1 << 8) | 'h0B});
        verify("reset_exec");

        // Random frames with garbage prefixes and random byte gaps.
        for (int n = 0; n < 40; n++) begin
            int r, len, ng;
            logic [7:0] g, x;
            ng = $urandom_range(0, 2);
            for (int k = 0; k < ng; k++) begin
                do g = 8'($urandom); while (g == 8'hA5);
                send(g, t);
                idle($urandom_range(0, 2));
            end
            r = $urandom_range(0, 9);
            f = '{8'hA5};
            f.push_back(r < 4 ? 8'h01 : r < 6 ? 8'h02 : r < 8 ? 8'h03 : r < 9 ? 8'h04
                                      : 8'($urandom_range(5, 255)));
            f.push_back(8'($urandom_range(0, 19)));
            len = (f[1] == 8'h01) ? $urandom_range(0, 5) : ($urandom_range(0, 4) == 0 ? 1 : 0);
            f.push_back(8'(len));
            if (!is_bad(f)) begin
                x = f[1] ^ f[2] ^ f[3];
                for (int i = 0; i < len; i++) begin
                    f.push_back(8'($urandom));
                    x ^= f[4 + i];
                end
                if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
                f.push_back(x);
            end
            run_frame("random", f, 3);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
